// File: rtl/rs_alu.sv
// -----------------------------------------------------------------------------
// rs_alu -- reservation station in front of the integer ALU.
//
// Buffers dispatched ALU/branch/jump micro-ops and captures missing operands
// from the ALU and LSB common data buses. It issues at most one fully-ready
// entry per cycle as a registered one-cycle pulse on RS_sgn, with the operands
// on RS_opcode/lhs/rhs/imm/pc/ROB_entry.
//
// Parameters
//   RS_SIZE  number of entries (power of two)
//   ROB_W    ROB tag width
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rdy               global enable (low = stall, all state holds)
//   rob_clear         misprediction flush (empties the station)
//   disp_*            dispatch request: opcode, operand values/tags, imm, pc, rob
//   rs_full           no free entry (decoded from the registered busy vector)
//   cdb_alu_*         ALU broadcast: valid, tag, result
//   cdb_lsb_*         LSB broadcast: valid, tag, result
//   RS_sgn            issue pulse
//   RS_opcode, lhs, rhs, imm, pc, ROB_entry   issued micro-op (hold when idle)
// -----------------------------------------------------------------------------
module rs_alu #(
   parameter int RS_SIZE = 8,
   parameter int ROB_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rob_clear,
   input  logic             disp_valid,
   input  logic [5:0]       disp_opcode,
   input  logic [31:0]      disp_vj,
   input  logic [31:0]      disp_vk,
   input  logic             disp_qj_busy,
   input  logic             disp_qk_busy,
   input  logic [ROB_W-1:0] disp_qj,
   input  logic [ROB_W-1:0] disp_qk,
   input  logic [31:0]      disp_imm,
   input  logic [31:0]      disp_pc,
   input  logic [ROB_W-1:0] disp_rob,
   output logic             rs_full,
   input  logic             cdb_alu_sgn,
   input  logic             cdb_lsb_sgn,
   input  logic [ROB_W-1:0] cdb_alu_rob,
   input  logic [ROB_W-1:0] cdb_lsb_rob,
   input  logic [31:0]      cdb_alu_result,
   input  logic [31:0]      cdb_lsb_result,
   output logic             RS_sgn,
   output logic [5:0]       RS_opcode,
   output logic [31:0]      lhs,
   output logic [31:0]      rhs,
   output logic [31:0]      imm,
   output logic [31:0]      pc,
   output logic [ROB_W-1:0] ROB_entry
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;

   // Resolves one operand against both CDB buses. Returns {still_pending, value}.
   // The ALU bus has priority if both buses carry the same tag.
   function automatic logic [32:0] resolve_operand(
      input logic             pending,
      input logic [ROB_W-1:0] tag,
      input logic [31:0]      value,
      input logic             alu_sgn,
      input logic [ROB_W-1:0] alu_rob,
      input logic [31:0]      alu_res,
      input logic             lsb_sgn,
      input logic [ROB_W-1:0] lsb_rob,
      input logic [31:0]      lsb_res
   );
      logic [32:0] res;
      if (pending && alu_sgn && (alu_rob == tag)) begin
         res = {1'b0, alu_res};
      end else if (pending && lsb_sgn && (lsb_rob == tag)) begin
         res = {1'b0, lsb_res};
      end else begin
         res = {pending, value};
      end
      return res;
   endfunction

   // Entry state
   logic [RS_SIZE-1:0] busy_r;
   logic [RS_SIZE-1:0] qj_busy_r;
   logic [RS_SIZE-1:0] qk_busy_r;
   logic [5:0]         opcode_r [RS_SIZE];
   logic [31:0]        vj_r     [RS_SIZE];
   logic [31:0]        vk_r     [RS_SIZE];
   logic [ROB_W-1:0]   qj_r     [RS_SIZE];
   logic [ROB_W-1:0]   qk_r     [RS_SIZE];
   logic [31:0]        imm_r    [RS_SIZE];
   logic [31:0]        pc_r     [RS_SIZE];
   logic [ROB_W-1:0]   rob_r    [RS_SIZE];

   // Output registers
   logic               rs_sgn_r;
   logic [5:0]         rs_opcode_r;
   logic [31:0]        lhs_r;
   logic [31:0]        rhs_r;
   logic [31:0]        imm_out_r;
   logic [31:0]        pc_out_r;
   logic [ROB_W-1:0]   rob_out_r;

   // Combinational helpers
   logic               free_found_s;
   logic [IDX_W-1:0]   free_idx_s;
   logic               sel_found_s;
   logic [IDX_W-1:0]   sel_idx_s;
   logic               active_s;
   logic               disp_s;
   logic               issue_s;
   logic [32:0]        disp_j_s;
   logic [32:0]        disp_k_s;
   logic [32:0]        wake_j_s [RS_SIZE];
   logic [32:0]        wake_k_s [RS_SIZE];

   // Full flag straight from the registered busy vector.
   assign rs_full = &busy_r;

   // Lowest free slot for dispatch and lowest ready slot for issue.
   // Scanning from the top down lets the lowest index overwrite last.
   always_comb begin
      free_found_s = 1'b0;
      free_idx_s   = {IDX_W{1'b0}};
      sel_found_s  = 1'b0;
      sel_idx_s    = {IDX_W{1'b0}};
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         free_found_s = (!busy_r[i]) ? 1'b1 : free_found_s;
         free_idx_s   = (!busy_r[i]) ? IDX_W'(i) : free_idx_s;
         sel_found_s  = (busy_r[i] && !qj_busy_r[i] && !qk_busy_r[i]) ? 1'b1 : sel_found_s;
         sel_idx_s    = (busy_r[i] && !qj_busy_r[i] && !qk_busy_r[i]) ? IDX_W'(i) : sel_idx_s;
      end
   end

   // Per-cycle enables: the flush and the stall both suppress dispatch,
   // wakeup and issue.
   always_comb begin
      active_s = rdy && !rob_clear;
      disp_s   = active_s && disp_valid && free_found_s;
      issue_s  = active_s && sel_found_s;
   end

   // Operand resolution for the dispatched op (same-cycle CDB bypass) and
   // for every stored entry (wakeup).
   always_comb begin
      disp_j_s = resolve_operand(disp_qj_busy, disp_qj, disp_vj,
                                 cdb_alu_sgn, cdb_alu_rob, cdb_alu_result,
                                 cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_result);
      disp_k_s = resolve_operand(disp_qk_busy, disp_qk, disp_vk,
                                 cdb_alu_sgn, cdb_alu_rob, cdb_alu_result,
                                 cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_result);
      for (int i = 0; i < RS_SIZE; i++) begin
         wake_j_s[i] = resolve_operand(qj_busy_r[i], qj_r[i], vj_r[i],
                                       cdb_alu_sgn, cdb_alu_rob, cdb_alu_result,
                                       cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_result);
         wake_k_s[i] = resolve_operand(qk_busy_r[i], qk_r[i], vk_r[i],
                                       cdb_alu_sgn, cdb_alu_rob, cdb_alu_result,
                                       cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_result);
      end
   end

   // Entry storage: reset, flush, wakeup, issue release and dispatch write.
   // The dispatch slot is never busy and the issue slot always is, so the
   // two never touch the same entry in one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r    <= {RS_SIZE{1'b0}};
         qj_busy_r <= {RS_SIZE{1'b0}};
         qk_busy_r <= {RS_SIZE{1'b0}};
         for (int i = 0; i < RS_SIZE; i++) begin
            opcode_r[i] <= 6'd0;
            vj_r[i]     <= 32'd0;
            vk_r[i]     <= 32'd0;
            qj_r[i]     <= {ROB_W{1'b0}};
            qk_r[i]     <= {ROB_W{1'b0}};
            imm_r[i]    <= 32'd0;
            pc_r[i]     <= 32'd0;
            rob_r[i]    <= {ROB_W{1'b0}};
         end
      end else if (rdy) begin
         if (rob_clear) begin
            busy_r <= {RS_SIZE{1'b0}};
         end else begin
            for (int i = 0; i < RS_SIZE; i++) begin
               if (busy_r[i]) begin
                  {qj_busy_r[i], vj_r[i]} <= wake_j_s[i];
                  {qk_busy_r[i], vk_r[i]} <= wake_k_s[i];
               end
            end
            if (issue_s) begin
               busy_r[sel_idx_s] <= 1'b0;
            end
            if (disp_s) begin
               busy_r[free_idx_s]    <= 1'b1;
               opcode_r[free_idx_s]  <= disp_opcode;
               qj_busy_r[free_idx_s] <= disp_j_s[32];
               vj_r[free_idx_s]      <= disp_j_s[31:0];
               qk_busy_r[free_idx_s] <= disp_k_s[32];
               vk_r[free_idx_s]      <= disp_k_s[31:0];
               qj_r[free_idx_s]      <= disp_qj;
               qk_r[free_idx_s]      <= disp_qk;
               imm_r[free_idx_s]     <= disp_imm;
               pc_r[free_idx_s]      <= disp_pc;
               rob_r[free_idx_s]     <= disp_rob;
            end
         end
      end
   end

   // Issue port: pulse RS_sgn and load the selected entry; data holds when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rs_sgn_r    <= 1'b0;
         rs_opcode_r <= 6'd0;
         lhs_r       <= 32'd0;
         rhs_r       <= 32'd0;
         imm_out_r   <= 32'd0;
         pc_out_r    <= 32'd0;
         rob_out_r   <= {ROB_W{1'b0}};
      end else if (issue_s) begin
         rs_sgn_r    <= 1'b1;
         rs_opcode_r <= opcode_r[sel_idx_s];
         lhs_r       <= vj_r[sel_idx_s];
         rhs_r       <= vk_r[sel_idx_s];
         imm_out_r   <= imm_r[sel_idx_s];
         pc_out_r    <= pc_r[sel_idx_s];
         rob_out_r   <= rob_r[sel_idx_s];
      end else begin
         rs_sgn_r    <= 1'b0;
      end
   end

   assign RS_sgn    = rs_sgn_r;
   assign RS_opcode = rs_opcode_r;
   assign lhs       = lhs_r;
   assign rhs       = rhs_r;
   assign imm       = imm_out_r;
   assign pc        = pc_out_r;
   assign ROB_entry = rob_out_r;

endmodule

// File: tb/tb_rs_alu.sv
// -----------------------------------------------------------------------------
// tb_rs_alu -- self-checking bench for rs_alu.
// Expected issues are queued when dispatched; a negedge monitor pops and
// compares each RS_sgn pulse. Timing points are checked inline.
// -----------------------------------------------------------------------------
module tb_rs_alu;

   logic        clk = 1'b0;
   logic        rst, rdy, rob_clear, disp_valid;
   logic [5:0]  disp_opcode;
   logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
   logic        disp_qj_busy, disp_qk_busy;
   logic [3:0]  disp_qj, disp_qk, disp_rob;
   logic        rs_full;
   logic        cdb_alu_sgn, cdb_lsb_sgn;
   logic [3:0]  cdb_alu_rob, cdb_lsb_rob;
   logic [31:0] cdb_alu_result, cdb_lsb_result;
   logic        RS_sgn;
   logic [5:0]  RS_opcode;
   logic [31:0] lhs, rhs, imm, pc;
   logic [3:0]  ROB_entry;

   typedef struct packed {
      logic [5:0]  op;
      logic [31:0] lhs;
      logic [31:0] rhs;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [3:0]  rob;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   issue_cnt = 0;

   rs_alu #(.RS_SIZE(8), .ROB_W(4)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_clear(rob_clear),
      .disp_valid(disp_valid), .disp_opcode(disp_opcode),
      .disp_vj(disp_vj), .disp_vk(disp_vk),
      .disp_qj_busy(disp_qj_busy), .disp_qk_busy(disp_qk_busy),
      .disp_qj(disp_qj), .disp_qk(disp_qk),
      .disp_imm(disp_imm), .disp_pc(disp_pc), .disp_rob(disp_rob),
      .rs_full(rs_full),
      .cdb_alu_sgn(cdb_alu_sgn), .cdb_lsb_sgn(cdb_lsb_sgn),
      .cdb_alu_rob(cdb_alu_rob), .cdb_lsb_rob(cdb_lsb_rob),
      .cdb_alu_result(cdb_alu_result), .cdb_lsb_result(cdb_lsb_result),
      .RS_sgn(RS_sgn), .RS_opcode(RS_opcode), .lhs(lhs), .rhs(rhs),
      .imm(imm), .pc(pc), .ROB_entry(ROB_entry)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic drive_disp(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic qjb, input logic [3:0] qj, input logic qkb,
                             input logic [3:0] qk, input logic [31:0] im, input logic [31:0] p,
                             input logic [3:0] rb);
      disp_valid   = 1'b1;
      disp_opcode  = op;
      disp_vj      = vj;
      disp_vk      = vk;
      disp_qj_busy = qjb;
      disp_qj      = qj;
      disp_qk_busy = qkb;
      disp_qk      = qk;
      disp_imm     = im;
      disp_pc      = p;
      disp_rob     = rb;
   endtask

   task automatic push_exp(input logic [5:0] op, input logic [31:0] l, input logic [31:0] r,
                           input logic [31:0] im, input logic [31:0] p, input logic [3:0] rb);
      exp_t e;
      e.op  = op;
      e.lhs = l;
      e.rhs = r;
      e.imm = im;
      e.pc  = p;
      e.rob = rb;
      sb_q.push_back(e);
   endtask

   // Scoreboard monitor: every issue pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && RS_sgn) begin
         issue_cnt++;
         if (sb_q.size() == 0) begin
            check_eq("unexpected_issue_rob", 64'(ROB_entry), 64'hFFFF);
         end else begin
            e = sb_q.pop_front();
            check_eq("sb_opcode", 64'(RS_opcode), 64'(e.op));
            check_eq("sb_lhs",    64'(lhs),       64'(e.lhs));
            check_eq("sb_rhs",    64'(rhs),       64'(e.rhs));
            check_eq("sb_imm",    64'(imm),       64'(e.imm));
            check_eq("sb_pc",     64'(pc),        64'(e.pc));
            check_eq("sb_rob",    64'(ROB_entry), 64'(e.rob));
         end
      end
   end

   initial begin
      rst = 1'b1; rdy = 1'b1; rob_clear = 1'b0; disp_valid = 1'b0;
      disp_opcode = 6'd0; disp_vj = 32'd0; disp_vk = 32'd0; disp_imm = 32'd0;
      disp_pc = 32'd0; disp_qj_busy = 1'b0; disp_qk_busy = 1'b0;
      disp_qj = 4'd0; disp_qk = 4'd0; disp_rob = 4'd0;
      cdb_alu_sgn = 1'b0; cdb_lsb_sgn = 1'b0; cdb_alu_rob = 4'd0; cdb_lsb_rob = 4'd0;
      cdb_alu_result = 32'd0; cdb_lsb_result = 32'd0;

      // Reset state
      repeat (3) tick();
      at_neg();
      check_eq("rst_sgn",    64'(RS_sgn),    64'd0);
      check_eq("rst_full",   64'(rs_full),   64'd0);
      check_eq("rst_opcode", 64'(RS_opcode), 64'd0);
      check_eq("rst_lhs",    64'(lhs),       64'd0);
      check_eq("rst_rhs",    64'(rhs),       64'd0);
      check_eq("rst_imm",    64'(imm),       64'd0);
      check_eq("rst_pc",     64'(pc),        64'd0);
      check_eq("rst_rob",    64'(ROB_entry), 64'd0);
      rst = 1'b0;
      tick();

      // 1: ready ADDI, issue two edges after dispatch, single-cycle pulse
      drive_disp(6'd2, 32'd5, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 32'd3, 32'h1000, 4'd2);
      push_exp(6'd2, 32'd5, 32'd0, 32'd3, 32'h1000, 4'd2);
      tick();
      disp_valid = 1'b0;
      at_neg(); check_eq("t1_early", 64'(RS_sgn), 64'd0);
      tick();
      at_neg(); check_eq("t1_issue", 64'(RS_sgn), 64'd1);
      tick();
      at_neg(); check_eq("t1_pulse", 64'(RS_sgn), 64'd0);

      // 2: qj pending on tag 4, woken by ALU CDB later
      drive_disp(6'd0, 32'hDEAD, 32'd7, 1'b1, 4'd4, 1'b0, 4'd0, 32'd0, 32'h1004, 4'd3);
      tick();
      disp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         at_neg(); check_eq("t2_wait", 64'(RS_sgn), 64'd0);
         tick();
      end
      cdb_alu_sgn = 1'b1; cdb_alu_rob = 4'd4; cdb_alu_result = 32'h10;
      push_exp(6'd0, 32'h10, 32'd7, 32'd0, 32'h1004, 4'd3);
      tick();
      cdb_alu_sgn = 1'b0;
      at_neg(); check_eq("t2_bcast_edge", 64'(RS_sgn), 64'd0);
      tick();
      at_neg(); check_eq("t2_issue", 64'(RS_sgn), 64'd1);
      tick();

      // 3: dispatch-cycle bypass from LSB CDB
      drive_disp(6'd1, 32'h11, 32'hBEEF, 1'b0, 4'd0, 1'b1, 4'd7, 32'd0, 32'h1008, 4'd5);
      cdb_lsb_sgn = 1'b1; cdb_lsb_rob = 4'd7; cdb_lsb_result = 32'hAA;
      push_exp(6'd1, 32'h11, 32'hAA, 32'd0, 32'h1008, 4'd5);
      tick();
      disp_valid = 1'b0; cdb_lsb_sgn = 1'b0;
      at_neg(); check_eq("t3_early", 64'(RS_sgn), 64'd0);
      tick();
      at_neg(); check_eq("t3_issue", 64'(RS_sgn), 64'd1);
      tick();

      // 4: fill the station, drop an extra dispatch, drain in index order
      for (int i = 0; i < 8; i++) begin
         drive_disp(6'd3, 32'h0BAD, 32'h100 + 32'(i), 1'b1, 4'd1, 1'b0, 4'd0,
                    32'(i), 32'h2000 + 32'(4 * i), 4'(i));
         push_exp(6'd3, 32'h55, 32'h100 + 32'(i), 32'(i), 32'h2000 + 32'(4 * i), 4'(i));
         tick();
      end
      disp_valid = 1'b0;
      at_neg(); check_eq("t4_full", 64'(rs_full), 64'd1);
      drive_disp(6'd4, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h2FFF, 4'd15);
      tick();
      disp_valid = 1'b0;
      at_neg(); check_eq("t4_full_after_drop", 64'(rs_full), 64'd1);
      check_eq("t4_no_issue", 64'(RS_sgn), 64'd0);
      cdb_alu_sgn = 1'b1; cdb_alu_rob = 4'd1; cdb_alu_result = 32'h55;
      tick();
      cdb_alu_sgn = 1'b0;
      at_neg(); check_eq("t4_full_at_wake", 64'(rs_full), 64'd1);
      check_eq("t4_wake_edge", 64'(RS_sgn), 64'd0);
      for (int i = 0; i < 8; i++) begin
         tick();
         at_neg(); check_eq("t4_drain", 64'(RS_sgn), 64'd1);
         check_eq("t4_not_full", 64'(rs_full), 64'd0);
      end
      tick();
      at_neg(); check_eq("t4_drained", 64'(RS_sgn), 64'd0);

      // 5: five pending entries flushed together with a dispatch
      for (int i = 0; i < 5; i++) begin
         drive_disp(6'd5, 32'd0, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 32'h3100, 4'(i));
         tick();
      end
      drive_disp(6'd5, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 32'h3200, 4'd9);
      rob_clear = 1'b1;
      tick();
      rob_clear = 1'b0;
      drive_disp(6'd7, 32'h77, 32'h88, 1'b0, 4'd0, 1'b0, 4'd0, 32'h99, 32'h3000, 4'd10);
      push_exp(6'd7, 32'h77, 32'h88, 32'h99, 32'h3000, 4'd10);
      at_neg(); check_eq("t5_flush_sgn", 64'(RS_sgn), 64'd0);
      check_eq("t5_flush_full", 64'(rs_full), 64'd0);
      tick();
      disp_valid = 1'b0;
      at_neg(); check_eq("t5_post_flush", 64'(RS_sgn), 64'd0);
      cdb_alu_sgn = 1'b1; cdb_alu_rob = 4'd3; cdb_alu_result = 32'h66;
      tick();
      cdb_alu_sgn = 1'b0;
      at_neg(); check_eq("t5_new_issue", 64'(RS_sgn), 64'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         at_neg(); check_eq("t5_no_ghost", 64'(RS_sgn), 64'd0);
      end

      // 6: ready entry held across a three-cycle stall
      drive_disp(6'd6, 32'h1234, 32'h5678, 1'b0, 4'd0, 1'b0, 4'd0, 32'h9A, 32'h4000, 4'd12);
      push_exp(6'd6, 32'h1234, 32'h5678, 32'h9A, 32'h4000, 4'd12);
      tick();
      disp_valid = 1'b0;
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         at_neg(); check_eq("t6_stall_sgn", 64'(RS_sgn), 64'd0);
         check_eq("t6_hold_lhs", 64'(lhs), 64'h77);
         check_eq("t6_hold_rob", 64'(ROB_entry), 64'd10);
      end
      rdy = 1'b1;
      tick();
      at_neg(); check_eq("t6_resume_issue", 64'(RS_sgn), 64'd1);
      tick();
      at_neg(); check_eq("t6_pulse", 64'(RS_sgn), 64'd0);

      // Final accounting
      tick();
      check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
      check_eq("issue_count", 64'(issue_cnt), 64'd13);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
